// File: rtl/traffic_light_if.sv
// Handshake/lamp bundle between the traffic-light controller and whatever
// drives its time base and requests.
interface traffic_light_if;
  logic       tick;
  logic       ped_req;
  logic       flash_mode;
  logic       ns_r, ns_y, ns_g;
  logic       ew_r, ew_y, ew_g;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state;

  modport master (
    output tick, ped_req, flash_mode,
    input  ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_pending, state
  );
  modport slave (
    input  tick, ped_req, flash_mode,
    output ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_pending, state
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light controller: all-red clearance, pedestrian walk with
// early green cut, night flash. All timing is in ticks of tl.tick.
module traffic_light_ctrl #(
  parameter int CNT_W       = 8,
  parameter int T_GREEN     = 20,
  parameter int T_MIN_GREEN = 5,
  parameter int T_YELLOW    = 4,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 10,
  parameter int T_FLASH     = 1
) (
  input  logic           clk,
  input  logic           rst,
  traffic_light_if.slave tl
);

  typedef enum logic [2:0] {
    NS_G = 3'd0, NS_Y = 3'd1, AR = 3'd2, EW_G = 3'd3,
    EW_Y = 3'd4, PED = 3'd5, FLASH = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] G_END  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] MG_END = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_END  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_END = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] W_END  = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] F_END  = CNT_W'(T_FLASH - 1);

  // lamp vector order: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
  localparam logic [6:0] LAMPS_ALLRED = 7'b1001000;

  state_t           st, st_nx;
  logic [CNT_W-1:0] elapsed, elapsed_nx;
  logic             dir_ew, dir_nx;
  logic             pend, pend_nx;
  logic             blink, blink_nx;
  logic [6:0]       lamp_q;

  function automatic logic [6:0] decode(state_t s, logic b);
    case (s)
      NS_G:    decode = 7'b0011000;
      NS_Y:    decode = 7'b0101000;
      EW_G:    decode = 7'b1000010;
      EW_Y:    decode = 7'b1000100;
      PED:     decode = 7'b1001001;
      FLASH:   decode = {1'b0, b, 1'b0, b, 3'b000};
      default: decode = LAMPS_ALLRED;
    endcase
  endfunction

  always_comb begin
    st_nx      = st;
    elapsed_nx = elapsed;
    dir_nx     = dir_ew;
    pend_nx    = pend;
    blink_nx   = blink;
    if (tl.ped_req && st != PED && st != FLASH)
      pend_nx = 1'b1;
    if (tl.tick) begin
      elapsed_nx = elapsed + 1'b1;
      case (st)
        NS_G, EW_G:
          if (elapsed == G_END || (pend && elapsed >= MG_END))
            st_nx = (st == NS_G) ? NS_Y : EW_Y;
        NS_Y:
          if (elapsed == Y_END) begin
            st_nx  = AR;
            dir_nx = 1'b1;
          end
        EW_Y:
          if (elapsed == Y_END) begin
            st_nx  = AR;
            dir_nx = 1'b0;
          end
        AR:
          if (elapsed == AR_END) begin
            // clearing here wins over a same-cycle ped_req: the walk/flash serves it
            if (tl.flash_mode) begin
              st_nx   = FLASH;
              pend_nx = 1'b0;
            end else if (pend) begin
              st_nx   = PED;
              pend_nx = 1'b0;
            end else begin
              st_nx = dir_ew ? EW_G : NS_G;
            end
          end
        PED:
          if (elapsed == W_END)
            st_nx = dir_ew ? EW_G : NS_G;
        FLASH:
          if (!tl.flash_mode) begin
            st_nx    = AR;
            dir_nx   = 1'b0;
            blink_nx = 1'b0;
          end else if (elapsed == F_END) begin
            blink_nx   = ~blink;
            elapsed_nx = '0;
          end
        default: st_nx = AR;
      endcase
      if (st_nx != st)
        elapsed_nx = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= AR;
      elapsed <= '0;
      dir_ew  <= 1'b0;
      pend    <= 1'b0;
      blink   <= 1'b0;
      lamp_q  <= LAMPS_ALLRED;
    end else begin
      st      <= st_nx;
      elapsed <= elapsed_nx;
      dir_ew  <= dir_nx;
      pend    <= pend_nx;
      blink   <= blink_nx;
      lamp_q  <= decode(st_nx, blink_nx);
    end
  end

  assign {tl.ns_r, tl.ns_y, tl.ns_g, tl.ew_r, tl.ew_y, tl.ew_g, tl.walk} = lamp_q;
  assign tl.ped_pending = pend;
  assign tl.state       = st;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: phase-level reference model checked
// every cycle, plus literal phase lengths and lamp values.
module tb_traffic_light_ctrl;
  localparam int T_GREEN = 20, T_MIN_GREEN = 5, T_YELLOW = 4;
  localparam int T_ALLRED = 2, T_WALK = 10, T_FLASH = 1;
  localparam int S_NSG = 0, S_NSY = 1, S_AR = 2, S_EWG = 3, S_EWY = 4, S_PED = 5, S_FL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0, errors = 0;
  int   div = 1, tcnt = 0;

  traffic_light_if tl ();

  traffic_light_ctrl #(
    .CNT_W(8), .T_GREEN(T_GREEN), .T_MIN_GREEN(T_MIN_GREEN), .T_YELLOW(T_YELLOW),
    .T_ALLRED(T_ALLRED), .T_WALK(T_WALK), .T_FLASH(T_FLASH)
  ) dut (.clk(clk), .rst(rst), .tl(tl));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dut_lamps();
    return {tl.ns_r, tl.ns_y, tl.ns_g, tl.ew_r, tl.ew_y, tl.ew_g, tl.walk};
  endfunction

  // Reference model: phase name, ticks completed in it, direction owed next.
  int m_ph = S_AR, m_done = 0;
  bit m_to_ew = 0, m_pend = 0, m_blink = 0;

  function automatic logic [6:0] model_lamps();
    case (m_ph)
      S_NSG:   return 7'b0011000;
      S_NSY:   return 7'b0101000;
      S_EWG:   return 7'b1000010;
      S_EWY:   return 7'b1000100;
      S_PED:   return 7'b1001001;
      S_FL:    return {1'b0, m_blink, 1'b0, m_blink, 3'b000};
      default: return 7'b1001000;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_ph = S_AR; m_done = 0; m_to_ew = 0; m_pend = 0; m_blink = 0;
    end else begin
      bit new_pend;
      int nx;
      new_pend = m_pend | (tl.ped_req && m_ph != S_PED && m_ph != S_FL);
      if (tl.tick) begin
        nx = m_ph;
        m_done++;
        case (m_ph)
          S_NSG, S_EWG:
            if (m_done == T_GREEN || (m_pend && m_done >= T_MIN_GREEN)) nx = m_ph + 1;
          S_NSY: if (m_done == T_YELLOW) begin nx = S_AR; m_to_ew = 1; end
          S_EWY: if (m_done == T_YELLOW) begin nx = S_AR; m_to_ew = 0; end
          S_AR:
            if (m_done == T_ALLRED) begin
              if (tl.flash_mode) begin nx = S_FL; new_pend = 0; end
              else if (m_pend) begin nx = S_PED; new_pend = 0; end
              else nx = m_to_ew ? S_EWG : S_NSG;
            end
          S_PED: if (m_done == T_WALK) nx = m_to_ew ? S_EWG : S_NSG;
          default:
            if (!tl.flash_mode) begin nx = S_AR; m_to_ew = 0; m_blink = 0; end
            else if (m_done == T_FLASH) begin m_blink = ~m_blink; m_done = 0; end
        endcase
        if (nx != m_ph) begin m_ph = nx; m_done = 0; end
      end
      m_pend = new_pend;
    end
    chk("state", tl.state, m_ph);
    chk("lamps", dut_lamps(), model_lamps());
    chk("ped_pending", tl.ped_pending, m_pend);
    chk("safety", ((tl.ns_g | tl.ns_y) & (tl.ew_g | tl.ew_y)) | (tl.walk & (tl.ns_g | tl.ew_g)), 0);
  end

  // Time base: tick on every div-th cycle.
  initial forever begin
    @(negedge clk);
    #1;
    tcnt++;
    tl.tick = (tcnt % div == 0);
  end

  task automatic wait_for(input int s, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(tl.state) != s && n < budget);
    if (int'(tl.state) != s) chk("timeout_state", tl.state, s);
  endtask

  task automatic phase(input string name, input int s, input int exp);
    int n;
    wait_for(s, exp + 20, n);
    chk(name, n, exp);
  endtask

  task automatic pulse_ped();
    #1 tl.ped_req = 1'b1;
    @(negedge clk);
    #1 tl.ped_req = 1'b0;
  endtask

  initial begin
    int n;
    tl.tick = 1'b1; tl.ped_req = 1'b0; tl.flash_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", tl.state, S_AR);
    chk("reset_lamps", dut_lamps(), 7'b1001000);
    #1 rst = 1'b0;

    // Free-running cycle: AR 2, NS_G 20, NS_Y 4, AR 2, EW_G 20, EW_Y 4, AR 2.
    phase("ar_first", S_NSG, 2);
    begin
      int total = 0;
      wait_for(S_NSY, 40, n); chk("ns_green_len", n, 20); total += n;
      wait_for(S_AR, 40, n);  chk("ns_yellow_len", n, 4); total += n;
      wait_for(S_EWG, 40, n); chk("allred_len", n, 2);    total += n;
      wait_for(S_EWY, 40, n); chk("ew_green_len", n, 20); total += n;
      wait_for(S_AR, 40, n);  chk("ew_yellow_len", n, 4); total += n;
      wait_for(S_NSG, 40, n); chk("allred2_len", n, 2);   total += n;
      chk("cycle_len", total, 52);
    end

    // Request at NS_G tick 2: green cut at 5 ticks, then walk.
    repeat (2) @(negedge clk);
    pulse_ped();
    phase("ns_green_cut_rest", S_NSY, 2);
    chk("pending_in_yellow", tl.ped_pending, 1);
    phase("ns_yellow_ped", S_AR, 4);
    phase("allred_to_ped", S_PED, 2);
    chk("walk_lamp", tl.walk, 1);
    chk("pending_cleared", tl.ped_pending, 0);
    phase("walk_len", S_EWG, 10);

    // Request past minimum green: yellow on the next tick (17 ticks of green).
    repeat (15) @(negedge clk);
    pulse_ped();
    phase("ew_green_late_cut", S_EWY, 1);
    phase("ew_yellow_ped", S_AR, 4);
    phase("allred_to_ped2", S_PED, 2);
    // Request during walk is ignored.
    repeat (3) @(negedge clk);
    pulse_ped();
    phase("walk2_rest", S_NSG, 6);
    chk("no_pending_after_walk", tl.ped_pending, 0);
    phase("ns_green_full", S_NSY, 20);

    // Flash requested during EW_G: phases complete first.
    phase("ns_yellow_f", S_AR, 4);
    phase("allred_f", S_EWG, 2);
    #1 tl.flash_mode = 1'b1;
    phase("ew_green_flash_req", S_EWY, 20);
    phase("ew_yellow_flash_req", S_AR, 4);
    phase("allred_to_flash", S_FL, 2);
    chk("flash_entry_nsy", tl.ns_y, 0);
    @(negedge clk);
    chk("flash_blink_nsy", tl.ns_y, 1);
    chk("flash_blink_ewr", tl.ew_r, 1);
    @(negedge clk);
    chk("flash_blink_off", tl.ns_y, 0);
    repeat (3) @(negedge clk);
    #1 tl.flash_mode = 1'b0;
    phase("flash_exit", S_AR, 1);
    phase("allred_after_flash", S_NSG, 2);

    // Tick every 3rd cycle.
    #1 div = 3;
    wait_for(S_NSY, 200, n);
    phase("slow_yellow", S_AR, 12);
    phase("slow_allred", S_EWG, 6);

    // Async reset in the middle of NS_Y.
    #1 div = 1;
    wait_for(S_NSY, 300, n);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_state", tl.state, S_AR);
    chk("async_rst_lamps", dut_lamps(), 7'b1001000);
    @(negedge clk);
    #1 rst = 1'b0;
    phase("allred_after_rst", S_NSG, 2);
    phase("ns_green_after_rst", S_NSY, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised two-road (North-South / East-West) traffic-light controller with red/yellow/green per road. Includes an all-red clearance interval, a pedestrian walk phase with early green termination, and a night flash mode. All durations are counted in ticks of an external `tick` enable pulse, so one module serves any time base. Outputs drive lamp drivers directly.

Parameters:
- CNT_W, 8, width of the phase timer; every T_* value must be at most 2^CNT_W-1.
- T_GREEN, 20, green duration in ticks (>=1).
- T_MIN_GREEN, 5, minimum green before a pedestrian request may cut green short (1..T_GREEN).
- T_YELLOW, 4, yellow duration in ticks (>=1).
- T_ALLRED, 2, all-red clearance duration in ticks (>=1).
- T_WALK, 10, pedestrian walk duration in ticks (>=1).
- T_FLASH, 1, half-period of flash blinking in ticks (>=1).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- tick, in, 1, single-cycle time-base enable; timers advance only when tick=1.
- ped_req, in, 1, pedestrian button; any cycle high latches a request.
- flash_mode, in, 1, level; 1 requests night flash mode.
- ns_r / ns_y / ns_g, out, 1 each, NS lamps.
- ew_r / ew_y / ew_g, out, 1 each, EW lamps.
- walk, out, 1, pedestrian walk lamp.
- ped_pending, out, 1, latched pedestrian request awaiting service.
- state, out, 3, current state code: NS_G=0, NS_Y=1, AR=2, EW_G=3, EW_Y=4, PED=5, FLASH=6.

Behaviour:
- Reset (async): state=AR, nxt_dir=NS, elapsed=0, ped_pending=0, blink=0. Outputs: ns_r=ew_r=1, all others 0.
- Timer `elapsed` (CNT_W bits):
  - Cleared to 0 on every state change.
  - Incremented on each tick in which the state does not change.
  - A state of duration T exits on the tick where elapsed==T-1, so it lasts exactly T ticks.
- Transitions (evaluated only when tick=1):
  - NS_G -> NS_Y when elapsed==T_GREEN-1, or when ped_pending=1 and elapsed>=T_MIN_GREEN-1.
  - NS_Y -> AR after T_YELLOW; sets nxt_dir=EW.
  - EW_G / EW_Y mirror NS_G / NS_Y; EW_Y -> AR sets nxt_dir=NS.
  - AR at end of T_ALLRED, in priority order:
    1. flash_mode=1 -> FLASH, and ped_pending cleared.
    2. ped_pending=1 -> PED, and ped_pending cleared.
    3. Otherwise -> NS_G if nxt_dir=NS, else EW_G.
  - PED -> NS_G or EW_G per nxt_dir after T_WALK.
  - FLASH:
    - blink toggles each T_FLASH ticks (elapsed wraps to 0 at each toggle).
    - On the first tick with flash_mode=0: -> AR with nxt_dir=NS.
- Lamp decode (Moore, from state registers only):
  - Each road shows exactly one of r/y/g in non-flash states.
  - NS_G: ns_g, ew_r. NS_Y: ns_y, ew_r. EW_G: ew_g, ns_r. EW_Y: ew_y, ns_r.
  - AR: ns_r, ew_r. PED: ns_r, ew_r, walk.
  - FLASH: ns_y=blink, ew_r=blink, all other lamps 0.
- Safety invariant: a green and a walk, or two conflicting greens/yellows, are never simultaneously 1.
- Mode and request handling:
  - flash_mode is sampled only at AR exit; an ongoing green or yellow always completes.
  - ped_req is ignored while in PED or FLASH.
  - ped_req in the same cycle as a transition tick is latched and honoured at the next decision.
  - Repeated ped_req while already pending has no further effect.
- Reset asserted mid-operation returns immediately to the reset state regardless of tick.
- With tick held 0, state and elapsed are frozen; ped_req still latches.

Test Plan:
- Reset, defaults, tick every cycle, no requests:
  - AR 2 ticks -> NS_G 20 -> NS_Y 4 -> AR 2 -> EW_G 20 -> EW_Y 4 -> AR -> NS_G.
  - Check lamps in each state and total cycle length of 52 ticks.
- ped_req pulse at NS_G tick 2:
  - NS_G ends at tick 5; then NS_Y 4 -> AR 2 -> PED 10 (walk=1, all red) -> EW_G.
  - ped_pending is 1 from the request until PED entry.
- ped_req at NS_G tick 15 (already past minimum green): NS_Y begins on the next tick.
- ped_req during PED: no second walk phase; ped_pending stays 0.
- flash_mode=1 raised during EW_G:
  - EW_G and EW_Y complete, AR runs 2 ticks, then FLASH; ns_y/ew_r toggle every tick.
  - Drop flash_mode: AR 2 ticks -> NS_G.
- tick asserted every 3rd cycle: durations scale by 3 in clock cycles.
- rst mid NS_Y: outputs go to all-red asynchronously; sequence restarts from AR.
